// File: rtl/mod60_bcd_cascade_counter.sv
// Two-digit cascaded counter: mod-UNITS_MOD units digit carrying into a mod-TENS_MOD tens digit.
// Optional feature macro: DOWN_COUNT_EN adds an up_dn input for bidirectional counting.
module mod60_bcd_cascade_counter #(
  parameter int unsigned UNITS_MOD = 10,
  parameter int unsigned TENS_MOD  = 6
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] load_units,
  input  logic [2:0] load_tens,
`ifdef DOWN_COUNT_EN
  input  logic       up_dn,
`endif
  output logic [3:0] units,
  output logic [2:0] tens,
  output logic       tc,
  output logic       wrap,
  output logic       load_err
);

  localparam int unsigned UNITS_W = 4;
  localparam int unsigned TENS_W  = 3;
  // Terminal values held at digit width; TENS_MOD=8 itself would not fit in 3 bits
  localparam logic [UNITS_W-1:0] UNITS_MAX = UNITS_W'(UNITS_MOD - 1);
  localparam logic [TENS_W-1:0]  TENS_MAX  = TENS_W'(TENS_MOD - 1);

  generate
    if (UNITS_MOD < 2 || UNITS_MOD > 10) begin : g_bad_units
      $error("UNITS_MOD must be in 2..10");
    end
    if (TENS_MOD < 2 || TENS_MOD > 8) begin : g_bad_tens
      $error("TENS_MOD must be in 2..8");
    end
  endgenerate

  logic [UNITS_W-1:0] units_nxt;
  logic [TENS_W-1:0]  tens_nxt;
  logic               wrap_nxt;
  logic               load_err_nxt;
  logic               count_up;
  logic               units_max;
  logic               tens_max;
  logic               units_zero;
  logic               tens_zero;
  logic               load_ok;

`ifdef DOWN_COUNT_EN
  assign count_up = up_dn;
`else
  assign count_up = 1'b1;
`endif

  assign units_max  = (units == UNITS_MAX);
  assign tens_max   = (tens == TENS_MAX);
  assign units_zero = (units == '0);
  assign tens_zero  = (tens == '0);
  assign load_ok    = (load_units <= UNITS_MAX) && (load_tens <= TENS_MAX);

  // Zero-latency carry out so the next stage can use it as its enable
  assign tc = en & (count_up ? (units_max & tens_max) : (units_zero & tens_zero));

  // Next-state: load beats count, count beats hold
  always_comb begin
    units_nxt    = units;
    tens_nxt     = tens;
    wrap_nxt     = 1'b0;
    load_err_nxt = load_err;
    if (load) begin
      if (load_ok) begin
        units_nxt = load_units;
        tens_nxt  = load_tens;
      end else begin
        load_err_nxt = 1'b1;
      end
    end else if (en) begin
      if (count_up) begin
        if (units_max) begin
          units_nxt = '0;
          if (tens_max) begin
            tens_nxt = '0;
            wrap_nxt = 1'b1;
          end else begin
            tens_nxt = tens + TENS_W'(1);
          end
        end else begin
          units_nxt = units + UNITS_W'(1);
        end
      end else begin
        if (units_zero) begin
          units_nxt = UNITS_MAX;
          if (tens_zero) begin
            tens_nxt = TENS_MAX;
            wrap_nxt = 1'b1;
          end else begin
            tens_nxt = tens - TENS_W'(1);
          end
        end else begin
          units_nxt = units - UNITS_W'(1);
        end
      end
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      units    <= '0;
      tens     <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      units    <= units_nxt;
      tens     <= tens_nxt;
      wrap     <= wrap_nxt;
      load_err <= load_err_nxt;
    end
  end

endmodule

// File: tb/tb_mod60_bcd_cascade_counter.sv
// Directed self-checking bench for mod60_bcd_cascade_counter (default 00..59 configuration).
module tb_mod60_bcd_cascade_counter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic       load;
  logic [3:0] load_units;
  logic [2:0] load_tens;
`ifdef DOWN_COUNT_EN
  logic       up_dn;
`endif
  logic [3:0] units;
  logic [2:0] tens;
  logic       tc;
  logic       wrap;
  logic       load_err;

  int total = 0;
  int bad   = 0;

  mod60_bcd_cascade_counter #(.UNITS_MOD(10), .TENS_MOD(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .load       (load),
    .load_units (load_units),
    .load_tens  (load_tens),
`ifdef DOWN_COUNT_EN
    .up_dn      (up_dn),
`endif
    .units      (units),
    .tens       (tens),
    .tc         (tc),
    .wrap       (wrap),
    .load_err   (load_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input int u, input int t, input int w, input int e);
    check({tag, ".units"}, int'(units), u);
    check({tag, ".tens"}, int'(tens), t);
    check({tag, ".wrap"}, int'(wrap), w);
    check({tag, ".load_err"}, int'(load_err), e);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; load = 1'b0; load_units = '0; load_tens = '0;
`ifdef DOWN_COUNT_EN
    up_dn = 1'b1;
`endif
    // 1: reset held two cycles with en high
    tick(); tick();
    check_state("reset", 0, 0, 0, 0);
    check("reset.tc", int'(tc), 0);

    // 2: full 60-step up count from 00
    rst_n = 1'b1;
    for (int i = 1; i <= 61; i++) begin
      tick();
      check($sformatf("cnt%0d.units", i), int'(units), i % 10);
      check($sformatf("cnt%0d.tens", i), int'(tens), (i / 10) % 6);
      check($sformatf("cnt%0d.wrap", i), int'(wrap), (i == 60) ? 1 : 0);
      if (i == 59) check("cnt59.tc", int'(tc), 1);
      if (i == 58) check("cnt58.tc", int'(tc), 0);
    end

    // 3: load with en high ignores en, then count carries into tens
    load = 1'b1; load_units = 4'd9; load_tens = 3'd2;
    tick();
    check_state("load29", 9, 2, 0, 0);
    load = 1'b0;
    tick();
    check_state("after29", 0, 3, 0, 0);

    // 4: illegal loads hold digits and set the sticky error
    en = 1'b0; load = 1'b1; load_units = 4'd12; load_tens = 3'd1;
    tick();
    check_state("badunits", 0, 3, 0, 1);
    load_units = 4'd3; load_tens = 3'd6;
    tick();
    check_state("badtens", 0, 3, 0, 1);
    load_units = 4'd5; load_tens = 3'd4;
    tick();
    check_state("goodload", 5, 4, 0, 1);
    load = 1'b0; rst_n = 1'b0;
    tick();
    check_state("errclr", 0, 0, 0, 0);
    rst_n = 1'b1;

    // 5: reset at 59 with en high wins over the wrap
    load = 1'b1; load_units = 4'd9; load_tens = 3'd5;
    tick();
    check_state("load59", 9, 5, 0, 0);
    load = 1'b0; en = 1'b0;
    #1 check("tc59_en0", int'(tc), 0);
    en = 1'b1;
    #1 check("tc59_en1", int'(tc), 1);
    rst_n = 1'b0;
    tick();
    check_state("rst59", 0, 0, 0, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      en = (i % 2 == 0);
      tick();
      check($sformatf("tog%0d.units", i), int'(units), i / 2 + 1);
    end
    check("tog.tens", int'(tens), 0);

    // wrap drops when en falls right after a wrap
    load = 1'b1; load_units = 4'd9; load_tens = 3'd5; en = 1'b0;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    check_state("wrap", 0, 0, 1, 0);
    en = 1'b0;
    tick();
    check_state("wrap_en0", 0, 0, 0, 0);

`ifdef DOWN_COUNT_EN
    // 6: down count from 00 wraps to 59, then 58
    up_dn = 1'b0; en = 1'b1;
    #1 check("down.tc", int'(tc), 1);
    tick();
    check_state("down59", 9, 5, 1, 0);
    check("down59.tc", int'(tc), 0);
    tick();
    check_state("down58", 8, 5, 0, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
